// File: rtl/codec_intf.sv
// ----------------------------------------------------------------------------
// codec_intf
//   Front-end between the equaliser core and a CS4272 audio codec.
//   - Generates the codec clocks from one free-running 10-bit counter:
//     MCLK = clk/4, SCLK = clk/16, LRCLK = clk/1024 (low = left, high = right).
//   - Keeps the codec in reset (RSTn low) for RST_FRAMES full LRCLK frames
//     after rst_n is released.
//   - Deserialises I2S SDout into parallel signed left/right samples and
//     pulses vld for one clock when both are updated (once per frame).
//   - Serialises the left/right samples presented by the core onto SDin.
//
// Ports
//   clk      in   system clock (50 MHz)
//   rst_n    in   asynchronous active-low reset
//   MCLK     out  codec master clock, cnt[1]
//   SCLK     out  codec bit clock, cnt[3]
//   LRCLK    out  codec frame clock, cnt[9]
//   RSTn     out  codec reset, active low
//   SDout    in   I2S serial data from the codec ADC
//   SDin     out  I2S serial data to the codec DAC
//   lft_in   out  last received left sample (signed 16 b)
//   rht_in   out  last received right sample (signed 16 b)
//   vld      out  one-clock pulse when lft_in/rht_in update
//   lft_out  in   left sample to transmit (signed 16 b)
//   rht_out  in   right sample to transmit (signed 16 b)
// ----------------------------------------------------------------------------
module codec_intf #(
    parameter int unsigned RST_FRAMES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               MCLK,
    output logic               SCLK,
    output logic               LRCLK,
    output logic               RSTn,
    input  logic               SDout,
    output logic               SDin,
    output logic signed [15:0] lft_in,
    output logic signed [15:0] rht_in,
    output logic               vld,
    input  logic signed [15:0] lft_out,
    input  logic signed [15:0] rht_out
);

    logic        [9:0]  r_cnt;
    logic        [15:0] r_frm;
    logic               r_rstn;
    logic        [15:0] r_sr_l;
    logic        [15:0] r_sr_r;
    logic signed [15:0] r_lft_in;
    logic signed [15:0] r_rht_in;
    logic               r_vld;
    logic signed [15:0] r_hold_l;
    logic signed [15:0] r_hold_r;
    logic        [15:0] r_tx;
    logic               r_sdin;

    logic [4:0]  w_bit_cnt;
    logic        w_ch;
    logic        w_rx_en;
    logic        w_tx_edge;
    logic [15:0] w_sr_r_next;

    assign w_bit_cnt   = r_cnt[8:4];
    assign w_ch        = r_cnt[9];
    // Sample one clock before SCLK rises, only on the 16 data slots.
    assign w_rx_en     = (r_cnt[3:0] == 4'd7) && (w_bit_cnt >= 5'd1) && (w_bit_cnt <= 5'd16);
    assign w_tx_edge   = (r_cnt[3:0] == 4'd15);
    // Right LSB arrives in the same cycle the parallel outputs are loaded.
    assign w_sr_r_next = {r_sr_r[14:0], SDout};

    assign MCLK   = r_cnt[1];
    assign SCLK   = r_cnt[3];
    assign LRCLK  = r_cnt[9];
    assign RSTn   = r_rstn;
    assign SDin   = r_sdin;
    assign lft_in = r_lft_in;
    assign rht_in = r_rht_in;
    assign vld    = r_vld;

    // Timebase and codec reset sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_frm  <= '0;
            r_rstn <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 10'd1;
            if (!r_rstn && (r_cnt == 10'h3FF)) begin
                if (r_frm == 16'(RST_FRAMES - 1))
                    r_rstn <= 1'b1;
                else
                    r_frm <= r_frm + 16'd1;
            end
        end
    end

    // Receive: MSB-first shift per channel, parallel update after right LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_l   <= '0;
            r_sr_r   <= '0;
            r_lft_in <= '0;
            r_rht_in <= '0;
            r_vld    <= 1'b0;
        end else begin
            if (w_rx_en) begin
                if (w_ch)
                    r_sr_r <= w_sr_r_next;
                else
                    r_sr_l <= {r_sr_l[14:0], SDout};
            end
            if (r_cnt == 10'h307) begin
                r_lft_in <= signed'(r_sr_l);
                r_rht_in <= signed'(w_sr_r_next);
            end
            r_vld <= (r_cnt == 10'h307);
        end
    end

    // Transmit: capture at frame end, shift out on SCLK falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_tx     <= '0;
            r_sdin   <= 1'b0;
        end else begin
            if (r_cnt == 10'h3FF) begin
                r_hold_l <= lft_out;
                r_hold_r <= rht_out;
            end
            if (w_tx_edge) begin
                if (w_bit_cnt == 5'd0) begin
                    r_tx   <= w_ch ? r_hold_r : r_hold_l;
                    r_sdin <= w_ch ? r_hold_r[15] : r_hold_l[15];
                end else if (w_bit_cnt <= 5'd15) begin
                    // r_tx[14] is the bit that becomes MSB after this shift.
                    r_tx   <= {r_tx[14:0], 1'b0};
                    r_sdin <= r_tx[14];
                end else begin
                    r_sdin <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_intf.sv
module tb_codec_intf;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               MCLK, SCLK, LRCLK, RSTn;
    logic               SDout, SDin;
    logic signed [15:0] lft_in, rht_in;
    logic               vld;
    logic signed [15:0] lft_out, rht_out;

    int checks = 0;
    int errors = 0;

    // Bench timebase: clocks since rst_n release.
    int          tcyc;
    logic        loop;
    logic [15:0] rx_l, rx_r;
    logic        junk;
    logic        drv;

    codec_intf #(.RST_FRAMES(1)) dut (
        .clk(clk), .rst_n(rst_n), .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK),
        .RSTn(RSTn), .SDout(SDout), .SDin(SDin), .lft_in(lft_in),
        .rht_in(rht_in), .vld(vld), .lft_out(lft_out), .rht_out(rht_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcyc <= 0;
        else        tcyc <= tcyc + 1;
    end

    always @(negedge clk) junk <= 1'($urandom);

    // I2S source: data slot k (1..16) of a channel carries word bit 16-k,
    // all other slots carry random don't-care bits.
    function automatic logic i2s_bit(int c, logic [15:0] l, logic [15:0] r, logic j);
        int p, b;
        p = c % 1024;
        b = (p % 512) / 16;
        if (b >= 1 && b <= 16)
            return (p >= 512) ? r[16 - b] : l[16 - b];
        return j;
    endfunction

    assign drv   = i2s_bit(tcyc, rx_l, rx_r, junk);
    assign SDout = loop ? SDin : drv;

    task automatic wait_pos(input int p);
        int n = 0;
        while ((tcyc % 1024) != p && n < 2100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2100) begin
            checks++; errors++;
            $display("FAIL wait_pos timeout: pos %0d never reached (at %0d)", p, tcyc % 1024);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (MCLK  !== 1'b0) begin errors++; $display("FAIL reset MCLK got %b exp 0", MCLK); end
        checks++; if (SCLK  !== 1'b0) begin errors++; $display("FAIL reset SCLK got %b exp 0", SCLK); end
        checks++; if (LRCLK !== 1'b0) begin errors++; $display("FAIL reset LRCLK got %b exp 0", LRCLK); end
        checks++; if (RSTn  !== 1'b0) begin errors++; $display("FAIL reset RSTn got %b exp 0", RSTn); end
        checks++; if (SDin  !== 1'b0) begin errors++; $display("FAIL reset SDin got %b exp 0", SDin); end
        checks++; if (vld   !== 1'b0) begin errors++; $display("FAIL reset vld got %b exp 0", vld); end
        checks++; if (lft_in !== 16'h0) begin errors++; $display("FAIL reset lft_in got %h exp 0", lft_in); end
        checks++; if (rht_in !== 16'h0) begin errors++; $display("FAIL reset rht_in got %h exp 0", rht_in); end
    endtask

    task automatic test_clocks();
        rst_n = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            checks++; if (MCLK !== ((tcyc % 4) >= 2))
                begin errors++; $display("FAIL clk MCLK t=%0d got %b", tcyc, MCLK); end
            checks++; if (SCLK !== ((tcyc % 16) >= 8))
                begin errors++; $display("FAIL clk SCLK t=%0d got %b", tcyc, SCLK); end
            checks++; if (LRCLK !== ((tcyc % 1024) >= 512))
                begin errors++; $display("FAIL clk LRCLK t=%0d got %b", tcyc, LRCLK); end
            checks++; if (RSTn !== (tcyc >= 1024))
                begin errors++; $display("FAIL clk RSTn t=%0d got %b exp %b", tcyc, RSTn, tcyc >= 1024); end
            @(negedge clk);
        end
    endtask

    task automatic test_rx(input int nfr);
        int p;
        loop = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            wait_pos(0);
            rx_l = (f == 0) ? 16'hA5C3 : 16'($urandom);
            rx_r = (f == 0) ? 16'h1234 : 16'($urandom);
            for (int i = 0; i < 1024; i++) begin
                p = tcyc % 1024;
                checks++; if (vld !== (p == 'h308))
                    begin errors++; $display("FAIL rx vld pos=%h got %b", p, vld); end
                if (p == 'h308) begin
                    checks++; if (lft_in !== rx_l)
                        begin errors++; $display("FAIL rx lft_in got %h exp %h", lft_in, rx_l); end
                    checks++; if (rht_in !== rx_r)
                        begin errors++; $display("FAIL rx rht_in got %h exp %h", rht_in, rx_r); end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_tx(input int nfr);
        logic [15:0] wl, wr;
        logic e;
        int p, b;
        loop = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            wait_pos('h300);
            wl = (f == 0) ? 16'h8001 : 16'($urandom);
            wr = (f == 0) ? 16'h7FFE : 16'($urandom);
            lft_out = wl;
            rht_out = wr;
            wait_pos(0);
            // Change inputs after the capture point; SDin must not follow.
            lft_out = 16'($urandom);
            rht_out = 16'($urandom);
            for (int i = 0; i < 1024; i++) begin
                p = tcyc % 1024;
                b = (p % 512) / 16;
                e = 1'b0;
                if (b >= 1 && b <= 16) e = (p >= 512) ? wr[16 - b] : wl[16 - b];
                checks++; if (SDin !== e)
                    begin errors++; $display("FAIL tx SDin pos=%h got %b exp %b", p, SDin, e); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_loopback();
        logic [15:0] wl, wr;
        loop = 1'b1;
        wait_pos('h300);
        lft_out = 16'h0F0F;
        rht_out = 16'hF0F0;
        for (int f = 0; f < 4; f++) begin
            wait_pos('h308);
            if (f >= 1) begin
                checks++; if (vld !== 1'b1) begin errors++; $display("FAIL loop vld got %b exp 1", vld); end
                checks++; if (lft_in !== 16'h0F0F) begin errors++; $display("FAIL loop lft_in got %h exp 0f0f", lft_in); end
                checks++; if (rht_in !== 16'hF0F0) begin errors++; $display("FAIL loop rht_in got %h exp f0f0", rht_in); end
                checks++; if (RSTn !== 1'b1) begin errors++; $display("FAIL loop RSTn got %b exp 1", RSTn); end
            end
            @(negedge clk);
        end
        for (int f = 0; f < 4; f++) begin
            wait_pos('h310);
            wl = 16'($urandom);
            wr = 16'($urandom);
            lft_out = wl;
            rht_out = wr;
            wait_pos(0);
            wait_pos('h308);
            checks++; if (lft_in !== wl) begin errors++; $display("FAIL loop_rand lft_in got %h exp %h", lft_in, wl); end
            checks++; if (rht_in !== wr) begin errors++; $display("FAIL loop_rand rht_in got %h exp %h", rht_in, wr); end
        end
        loop = 1'b0;
    endtask

    task automatic test_midreset();
        int p;
        loop = 1'b0;
        wait_pos(0);
        rx_l = 16'($urandom);
        rx_r = 16'($urandom);
        wait_pos('h150);
        rst_n = 1'b0;
        #1;
        checks++; if (MCLK  !== 1'b0) begin errors++; $display("FAIL midrst MCLK got %b exp 0", MCLK); end
        checks++; if (SCLK  !== 1'b0) begin errors++; $display("FAIL midrst SCLK got %b exp 0", SCLK); end
        checks++; if (LRCLK !== 1'b0) begin errors++; $display("FAIL midrst LRCLK got %b exp 0", LRCLK); end
        checks++; if (RSTn  !== 1'b0) begin errors++; $display("FAIL midrst RSTn got %b exp 0", RSTn); end
        checks++; if (SDin  !== 1'b0) begin errors++; $display("FAIL midrst SDin got %b exp 0", SDin); end
        checks++; if (vld   !== 1'b0) begin errors++; $display("FAIL midrst vld got %b exp 0", vld); end
        checks++; if (lft_in !== 16'h0) begin errors++; $display("FAIL midrst lft_in got %h exp 0", lft_in); end
        checks++; if (rht_in !== 16'h0) begin errors++; $display("FAIL midrst rht_in got %h exp 0", rht_in); end
        @(negedge clk);
        rst_n = 1'b1;
        rx_l = 16'($urandom);
        rx_r = 16'($urandom);
        for (int i = 0; i < 1024; i++) begin
            p = tcyc % 1024;
            checks++; if (vld !== (p == 'h308))
                begin errors++; $display("FAIL midrst vld pos=%h got %b", p, vld); end
            checks++; if (RSTn !== 1'b0)
                begin errors++; $display("FAIL midrst RSTn early t=%0d got %b", tcyc, RSTn); end
            if (p == 'h308) begin
                checks++; if (lft_in !== rx_l)
                    begin errors++; $display("FAIL midrst lft_in got %h exp %h", lft_in, rx_l); end
                checks++; if (rht_in !== rx_r)
                    begin errors++; $display("FAIL midrst rht_in got %h exp %h", rht_in, rx_r); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        loop    = 1'b0;
        rx_l    = 16'h0;
        rx_r    = 16'h0;
        lft_out = 16'sh0;
        rht_out = 16'sh0;
        repeat (3) @(negedge clk);
        test_reset();
        test_clocks();
        test_rx(6);
        test_tx(5);
        test_loopback();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
